mem_io_responder: RTL and testbench



---
 rtl/mem_io_responder_pkg.sv | 17 +
 rtl/byte_fifo.sv | 56 +++++
 rtl/mem_io_responder.sv | 155 +++++++++++++++
 tb/tb_mem_io_responder.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_io_responder_pkg.sv
// Shared definitions for the CPU memory-bus responder.
// Holds the I/O window select, the I/O register addresses and the
// read-source tag carried from the request cycle into the data cycle.
package mem_io_responder_pkg;

  localparam logic [1:0]  IO_BASE_SEL  = 2'b11;
  localparam logic [31:0] IO_UART_ADDR = 32'h0003_0000;
  localparam logic [31:0] IO_CNT_ADDR  = 32'h0003_0004;

  typedef enum logic [1:0] {
    SRC_RAM,
    SRC_RX,
    SRC_CNT,
    SRC_ZERO
  } rd_src_e;

endpackage

// File: rtl/byte_fifo.sv
// Circular byte FIFO used for the UART TX queue.
// Ports:
//   clk_in, rst_in  clock, synchronous active-high reset (flushes contents)
//   push, push_data write one byte; ignored while full
//   pop             drop the head byte; ignored while empty
//   full, empty     occupancy flags
//   head            current head byte (valid while !empty)
module byte_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output logic [7:0] head
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mem_io_responder.sv
// Responder end of the CPU byte-wide memory bus.
// Decodes each request to RAM or to the I/O window (addr[17:16] == 2'b11),
// returns read data one cycle after the request, owns the UART TX FIFO,
// the RX pop path, the cycle counter and the sticky program-stop flag.
// Optional build macro: IO_CYCLE_COUNTER_EN (cycle counter + snapshot at
// 0x30004..0x30007; without it those reads return 0x00).
// Ports:
//   clk_in, rst_in           clock, synchronous active-high reset
//   cpu_addr/wr/wdata/rdata  CPU request and registered read byte
//   rdy_out                  CPU run enable, low while TX FIFO is full
//   ram_addr/we/wdata/rdata  external RAM (read data one cycle late)
//   rx_data/valid/pop        external UART RX queue head and pop
//   tx_data/valid/ready      TX FIFO head handshake to UART TX
//   program_stop             sticky, set by a write to 0x30004
module mem_io_responder
  import mem_io_responder_pkg::*;
#(
  parameter int unsigned TX_DEPTH = 16,
  parameter int unsigned CNT_W    = 32
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] cpu_addr,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        rdy_out,
  output logic [16:0] ram_addr,
  output logic        ram_we,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_pop,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        program_stop
);

  logic       accepted;
  logic       io_sel;
  logic       is_uart;
  logic       is_cnt;
  logic       is_cnt0;
  logic       fifo_full;
  logic       fifo_empty;
  logic       tx_push;
  logic [7:0] tx_push_data;
  logic       stop_set;
  logic       stop_q;
  logic [7:0] rx_q;
  rd_src_e    src_d;
  rd_src_e    src_q;
  logic       unused_addr;

  assign unused_addr = ^cpu_addr[31:18];

  // Requests presented during reset are dropped so nothing leaks past it.
  assign accepted = !fifo_full && !rst_in;
  assign rdy_out  = !fifo_full;

  assign io_sel  = (cpu_addr[17:16] == IO_BASE_SEL);
  assign is_uart = io_sel && (cpu_addr[15:0] == IO_UART_ADDR[15:0]);
  assign is_cnt  = io_sel && (cpu_addr[15:2] == IO_CNT_ADDR[15:2]);
  assign is_cnt0 = is_cnt && (cpu_addr[1:0] == 2'b00);

  assign ram_addr  = cpu_addr[16:0];
  assign ram_wdata = cpu_wdata;
  assign ram_we    = accepted && cpu_wr && !io_sel;

  assign rx_pop = accepted && !cpu_wr && is_uart && rx_valid;

  assign stop_set     = accepted && cpu_wr && is_cnt0;
  assign tx_push      = (accepted && cpu_wr && is_uart && (cpu_wdata != '0)) || stop_set;
  assign tx_push_data = is_cnt0 ? '0 : cpu_wdata;

  always_comb begin
    src_d = SRC_ZERO;
    if (accepted && !cpu_wr) begin
      if (!io_sel)                  src_d = SRC_RAM;
      else if (is_uart && rx_valid) src_d = SRC_RX;
`ifdef IO_CYCLE_COUNTER_EN
      else if (is_cnt)              src_d = SRC_CNT;
`endif
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      src_q  <= SRC_ZERO;
      rx_q   <= '0;
      stop_q <= 1'b0;
    end else begin
      src_q <= src_d;
      if (rx_pop)   rx_q   <= rx_data;
      if (stop_set) stop_q <= 1'b1;
    end
  end

  assign program_stop = stop_q;

`ifdef IO_CYCLE_COUNTER_EN
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] snap_q;
  logic [1:0]       byte_sel_q;

  // Only byte 0 re-snapshots; bytes 1..3 come from the same snapshot so a
  // dword read across four cycles stays consistent.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt_q      <= '0;
      snap_q     <= '0;
      byte_sel_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
      if (src_d == SRC_CNT) begin
        byte_sel_q <= cpu_addr[1:0];
        if (cpu_addr[1:0] == 2'b00) snap_q <= cnt_q;
      end
    end
  end
`else
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

  always_comb begin
    cpu_rdata = '0;
    case (src_q)
      SRC_RAM: cpu_rdata = ram_rdata;
      SRC_RX:  cpu_rdata = rx_q;
`ifdef IO_CYCLE_COUNTER_EN
      SRC_CNT: cpu_rdata = snap_q[{byte_sel_q, 3'b000} +: 8];
`endif
      default: cpu_rdata = '0;
    endcase
  end

  byte_fifo #(
    .DEPTH(TX_DEPTH)
  ) u_tx_fifo (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .push      (tx_push),
    .push_data (tx_push_data),
    .pop       (tx_valid && tx_ready),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (tx_data)
  );

  assign tx_valid = !fifo_empty;

endmodule

// File: tb/tb_mem_io_responder.sv
module tb_mem_io_responder;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [31:0] cpu_addr;
  logic        cpu_wr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        rdy_out;
  logic [16:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_pop;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        program_stop;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] IDLE_ADDR = 32'h0003_000C;

  mem_io_responder #(
    .TX_DEPTH(16),
    .CNT_W(32)
  ) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .cpu_addr     (cpu_addr),
    .cpu_wr       (cpu_wr),
    .cpu_wdata    (cpu_wdata),
    .cpu_rdata    (cpu_rdata),
    .rdy_out      (rdy_out),
    .ram_addr     (ram_addr),
    .ram_we       (ram_we),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_pop       (rx_pop),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .program_stop (program_stop)
  );

  always #5 clk_in = ~clk_in;

  // External synchronous RAM: read data one cycle after the address.
  logic [7:0] ram_mem [131072];
  always @(posedge clk_in) begin
    if (ram_we) ram_mem[ram_addr] <= ram_wdata;
    ram_rdata <= ram_mem[ram_addr];
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic w, input logic [7:0] d);
    cpu_addr  = a;
    cpu_wr    = w;
    cpu_wdata = d;
  endtask

  task automatic idle();
    drive(IDLE_ADDR, 1'b0, 8'h00);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    idle();
    step();
    step();
    rst_in = 1'b0;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [7:0]  wdata;
    logic        rxv;
    logic [7:0]  rxd;
    logic        exp_we;
    logic [16:0] exp_ra;
    logic        exp_pop;
    logic [7:0]  exp_rd;
  } vec_t;

  vec_t vecs[12];
  logic [31:0] snap_exp;
  logic [7:0]  snap_b;

  initial begin
    tx_ready = 1'b0;
    do_reset();

    check("rst_cpu_rdata", cpu_rdata, 8'h00);
    check("rst_rdy_out", rdy_out, 1'b1);
    check("rst_ram_we", ram_we, 1'b0);
    check("rst_rx_pop", rx_pop, 1'b0);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_program_stop", program_stop, 1'b0);

    //            addr          wr  wdata  rxv  rxd    we  ram_addr   pop  rdata
    vecs[0]  = '{32'h0000_0010, 1, 8'h5A, 0, 8'h00, 1, 17'h00010, 0, 8'h00};
    vecs[1]  = '{32'h0000_0010, 0, 8'h00, 0, 8'h00, 0, 17'h00010, 0, 8'h5A};
    vecs[2]  = '{32'h0001_FFFF, 1, 8'hA5, 0, 8'h00, 1, 17'h1FFFF, 0, 8'h00};
    vecs[3]  = '{32'h0001_FFFF, 0, 8'h00, 0, 8'h00, 0, 17'h1FFFF, 0, 8'hA5};
    vecs[4]  = '{32'h0002_0010, 0, 8'h00, 0, 8'h00, 0, 17'h00010, 0, 8'h5A};
    vecs[5]  = '{32'h0003_0000, 0, 8'h00, 1, 8'h37, 0, 17'h10000, 1, 8'h37};
    vecs[6]  = '{32'h0003_0000, 0, 8'h00, 0, 8'h99, 0, 17'h10000, 0, 8'h00};
    vecs[7]  = '{32'h0003_0008, 0, 8'h00, 1, 8'h55, 0, 17'h10008, 0, 8'h00};
    vecs[8]  = '{32'h0003_0000, 1, 8'h00, 1, 8'h44, 0, 17'h10000, 0, 8'h00};
    vecs[9]  = '{32'h0003_0008, 1, 8'h66, 0, 8'h00, 0, 17'h10008, 0, 8'h00};
    vecs[10] = '{32'h0001_0010, 1, 8'hC3, 0, 8'h00, 1, 17'h10010, 0, 8'h00};
    vecs[11] = '{32'h0001_0010, 0, 8'h00, 0, 8'h00, 0, 17'h10010, 0, 8'hC3};

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].addr, vecs[i].wr, vecs[i].wdata);
      rx_valid = vecs[i].rxv;
      rx_data  = vecs[i].rxd;
      #1;
      check($sformatf("vec%0d_ram_we", i), ram_we, vecs[i].exp_we);
      check($sformatf("vec%0d_ram_addr", i), ram_addr, vecs[i].exp_ra);
      check($sformatf("vec%0d_rx_pop", i), rx_pop, vecs[i].exp_pop);
      step();
      idle();
      #1;
      check($sformatf("vec%0d_cpu_rdata", i), cpu_rdata, vecs[i].exp_rd);
      check($sformatf("vec%0d_ram_we_after", i), ram_we, 1'b0);
      step();
    end
    check("table_tx_valid", tx_valid, 1'b0);

    // TX: 0x41, 0x00 (dropped), 0x42, then drain.
    drive(32'h0003_0000, 1'b1, 8'h41); step();
    drive(32'h0003_0000, 1'b1, 8'h00); step();
    drive(32'h0003_0000, 1'b1, 8'h42); step();
    idle();
    check("tx_valid_loaded", tx_valid, 1'b1);
    check("tx_head_41", tx_data, 8'h41);
    tx_ready = 1'b1;
    step();
    check("tx_head_42", tx_data, 8'h42);
    check("tx_valid_42", tx_valid, 1'b1);
    step();
    check("tx_empty_after_2", tx_valid, 1'b0);
    tx_ready = 1'b0;

    // Fill to 16, hold a 17th write, one pop lets it in.
    for (int i = 1; i <= 16; i++) begin
      drive(32'h0003_0000, 1'b1, 8'(i));
      check($sformatf("fill_rdy_%0d", i), rdy_out, 1'b1);
      step();
    end
    drive(32'h0003_0000, 1'b1, 8'h77);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("full_rdy_%0d", i), rdy_out, 1'b0);
      step();
    end
    tx_ready = 1'b1;
    check("full_head", tx_data, 8'h01);
    step();
    tx_ready = 1'b0;
    check("rdy_after_pop", rdy_out, 1'b1);
    step();
    idle();
    check("rdy_refull", rdy_out, 1'b0);
    tx_ready = 1'b1;
    for (int j = 2; j <= 16; j++) begin
      check($sformatf("drain_%0d", j), tx_data, 8'(j));
      step();
    end
    check("drain_77", tx_data, 8'h77);
    check("drain_77_valid", tx_valid, 1'b1);
    step();
    check("drain_empty", tx_valid, 1'b0);
    tx_ready = 1'b0;

    // Counter snapshot: request 0x30004 at counter 0x1FE, bytes 1..3 follow.
    do_reset();
    repeat (510) step();
`ifdef IO_CYCLE_COUNTER_EN
    snap_exp = 32'h0000_01FE;
`else
    snap_exp = 32'h0000_0000;
`endif
    drive(32'h0003_0004, 1'b0, 8'h00);
    step();
    for (int b = 0; b < 4; b++) begin
      if (b < 3) drive(32'h0003_0005 + 32'(b), 1'b0, 8'h00);
      else idle();
      #1;
      snap_b = snap_exp[8*b +: 8];
      check($sformatf("cnt_byte%0d", b), cpu_rdata, snap_b);
      step();
    end

    // Stop write, sticky flag, reset mid-drain.
    drive(32'h0003_0004, 1'b1, 8'h5A);
    check("stop_before", program_stop, 1'b0);
    step();
    drive(32'h0003_0000, 1'b1, 8'h11);
    check("stop_set", program_stop, 1'b1);
    check("stop_tx_valid", tx_valid, 1'b1);
    check("stop_tx_zero", tx_data, 8'h00);
    step();
    idle();
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    check("mid_drain_head", tx_data, 8'h11);
    check("stop_sticky", program_stop, 1'b1);
    rst_in = 1'b1;
    drive(32'h0003_0000, 1'b0, 8'h00);
    rx_valid = 1'b1;
    rx_data  = 8'hAB;
    step();
    rst_in = 1'b0;
    idle();
    check("rst2_tx_valid", tx_valid, 1'b0);
    check("rst2_program_stop", program_stop, 1'b0);
    check("rst2_cpu_rdata", cpu_rdata, 8'h00);
    check("rst2_rdy_out", rdy_out, 1'b1);
    drive(32'h0003_0004, 1'b0, 8'h00);
    step();
    idle();
    check("rst2_counter_zero", cpu_rdata, 8'h00);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
